// File: rtl/div_seq.sv
// Radix-2 restoring divide sequencer for DIV/DIVU (quotient->LO, remainder->HI).
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and goes straight to FIX.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shift;
  logic [WIDTH:0]   diff;
  logic             ge;

  function automatic logic [WIDTH-1:0] neg(
    input logic [WIDTH-1:0] x
  );
    return ~x + ONE;
  endfunction

  assign accept = start & ~cancel &
                  ((state_q == IDLE) | (state_q == DONE));

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  // -2^(W-1) negates to itself, read as an unsigned magnitude
  assign a_mag = a_neg ? neg(dividend) : dividend;
  assign b_mag = b_neg ? neg(divisor) : divisor;

  assign shift = {prem_q, dvd_q[WIDTH-1]};
  assign diff  = shift - {1'b0, dvs_q};
  assign ge    = (shift >= {1'b0, dvs_q});

  assign busy = (state_q == CALC) | (state_q == FIX) |
                (start & (state_q == IDLE) & ~cancel);
  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (cancel) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (accept) begin
              dvs_q  <= b_mag;
              qneg_q <= a_neg ^ b_neg;
              rneg_q <= a_neg;
              if (FAST_ZERO && (divisor == '0)) begin
                prem_q  <= a_mag;
                dvd_q   <= '1;
                cnt_q   <= '0;
                state_q <= FIX;
              end else begin
                prem_q  <= '0;
                dvd_q   <= a_mag;
                cnt_q   <= CNT_INIT;
                state_q <= CALC;
              end
            end else begin
              state_q <= IDLE;
            end
          end
          CALC: begin
            prem_q <= ge ? diff[WIDTH-1:0] : shift[WIDTH-1:0];
            dvd_q  <= {dvd_q[WIDTH-2:0], ge};
            cnt_q  <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= FIX;
            end
          end
          FIX: begin
            quo_q   <= qneg_q ? neg(dvd_q) : dvd_q;
            rem_q   <= rneg_q ? neg(prem_q) : prem_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
